uart_cmd_parser: RTL and testbench

//  Parametrised successor to the UART control stage. Consumes the RX byte stream from the UART FIFO and parses framed commands:

---
 rtl/uart_cmd_parser.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Parses framed commands from the UART RX byte stream:
//     SYNC, CMD, LEN, PAYLOAD[LEN], CHK    with CHK = CMD ^ LEN ^ payload bytes
// A good frame raises one cmd_pulse strobe together with frame_ok. The buffered
// payload is then streamed out over a valid/ready interface. Bad frames raise
// one error strobe and leave no other trace.
//
// Optional feature macro: UART_CMD_TIMEOUT_EN
//     defined   - an inter-byte timeout aborts a frame stuck in CMD/LEN/PAY/CHK
//     undefined - no timeout counter is built and err_timeout is tied to 0
//
// Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     rx_data/valid      byte stream from the RX FIFO
//     rx_ready           byte accepted on rx_valid & rx_ready (0 while draining)
//     cmd_pulse          one-hot 1-cycle strobe for an accepted command
//     cmd_code           CMD of the last accepted frame (held)
//     frame_ok           1-cycle strobe coincident with cmd_pulse
//     pld_data/valid/    payload stream out; pld_last marks the final byte
//     pld_last/ready
//     err_chk/len/cmd    1-cycle error strobes
//     err_timeout        1-cycle timeout strobe
//     busy               high whenever the parser is not idle
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int         NUM_CMD        = 4,
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [NUM_CMD-1:0] cmd_pulse,
    output logic [7:0]         cmd_code,
    output logic               frame_ok,
    output logic [7:0]         pld_data,
    output logic               pld_valid,
    input  logic               pld_ready,
    output logic               pld_last,
    output logic               err_chk,
    output logic               err_len,
    output logic               err_cmd,
    output logic               err_timeout,
    output logic               busy
);

    localparam int PTR_W     = $clog2(MAX_LEN + 1);
    localparam int ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    localparam logic [PTR_W-1:0]   PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [7:0]         MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [8:0]         NUM_CMD_B = 9'(NUM_CMD);
    localparam logic [NUM_CMD-1:0] CMD_ONE   = NUM_CMD'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LEN   = 3'd2,
        ST_PAY   = 3'd3,
        ST_CHK   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    // Running checksum step: plain XOR fold of one byte.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t             state_r,     state_s;
    logic [7:0]         cmd_r,       cmd_s;
    logic [7:0]         len_r,       len_s;
    logic [7:0]         chk_r,       chk_s;
    logic [PTR_W-1:0]   wr_r,        wr_s;
    logic [PTR_W-1:0]   rd_r,        rd_s;
    logic [PTR_W-1:0]   rd_inc_s;
    logic [NUM_CMD-1:0] cmd_pulse_r, cmd_pulse_s;
    logic [7:0]         cmd_code_r,  cmd_code_s;
    logic               frame_ok_r,  frame_ok_s;
    logic [7:0]         pld_data_r,  pld_data_s;
    logic               pld_valid_r, pld_valid_s;
    logic               pld_last_r,  pld_last_s;
    logic               err_chk_r,   err_chk_s;
    logic               err_len_r,   err_len_s;
    logic               err_cmd_r,   err_cmd_s;
    logic               busy_r,      busy_s;
    logic               mem_we_s;
    logic               accept_s;
    logic               rx_ready_s;
    logic               pld_fire_s;

    // Payload storage; deliberately not reset, a byte is only read after it was written in this frame.
    logic [7:0] pay_mem [MEM_DEPTH];

`ifdef UART_CMD_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic             err_timeout_r, err_timeout_s;
`endif

    // rx_ready is the only output decoded straight from state.
    assign rx_ready_s = (state_r != ST_DRAIN);
    assign accept_s   = rx_valid & rx_ready_s;
    assign pld_fire_s = pld_valid_r & pld_ready;
    assign rd_inc_s   = rd_r + PTR_ONE;

    // Next-state and next-output decode for the frame parser.
    always_comb begin
        state_s     = state_r;
        cmd_s       = cmd_r;
        len_s       = len_r;
        chk_s       = chk_r;
        wr_s        = wr_r;
        rd_s        = rd_r;
        cmd_pulse_s = {NUM_CMD{1'b0}};
        cmd_code_s  = cmd_code_r;
        frame_ok_s  = 1'b0;
        pld_data_s  = pld_data_r;
        pld_valid_s = pld_valid_r;
        pld_last_s  = pld_last_r;
        err_chk_s   = 1'b0;
        err_len_s   = 1'b0;
        err_cmd_s   = 1'b0;
        mem_we_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                pld_valid_s = 1'b0;
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_s = ST_CMD;
                    wr_s    = PTR_ZERO;
                    rd_s    = PTR_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (accept_s) begin
                    cmd_s   = rx_data;
                    chk_s   = rx_data;
                    state_s = ST_LEN;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    if (rx_data > MAX_LEN_B) begin
                        err_len_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        len_s   = rx_data;
                        chk_s   = chk_fold(chk_r, rx_data);
                        state_s = (rx_data == 8'd0) ? ST_CHK : ST_PAY;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_PAY: begin
                if (accept_s) begin
                    mem_we_s = 1'b1;
                    chk_s    = chk_fold(chk_r, rx_data);
                    wr_s     = wr_r + PTR_ONE;
                    if (8'(wr_r) == (len_r - 8'd1)) begin
                        state_s = ST_CHK;
                    end else begin
                        state_s = ST_PAY;
                    end
                end else begin
                    state_s = ST_PAY;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (rx_data != chk_r) begin
                        err_chk_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else if ({1'b0, cmd_r} >= NUM_CMD_B) begin
                        err_cmd_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        cmd_pulse_s = CMD_ONE << cmd_r;
                        frame_ok_s  = 1'b1;
                        cmd_code_s  = cmd_r;
                        if (len_r != 8'd0) begin
                            // First payload byte is presented together with the strobe.
                            state_s     = ST_DRAIN;
                            pld_valid_s = 1'b1;
                            pld_data_s  = pay_mem[PTR_ZERO[ADDR_W-1:0]];
                            pld_last_s  = (len_r == 8'd1);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_DRAIN: begin
                if (pld_fire_s) begin
                    if (8'(rd_r) == (len_r - 8'd1)) begin
                        state_s     = ST_IDLE;
                        pld_valid_s = 1'b0;
                        pld_last_s  = 1'b0;
                    end else begin
                        rd_s       = rd_inc_s;
                        pld_data_s = pay_mem[rd_inc_s[ADDR_W-1:0]];
                        pld_last_s = (8'(rd_inc_s) == (len_r - 8'd1));
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                pld_valid_s = 1'b0;
            end
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        err_timeout_s = 1'b0;
        if ((state_r == ST_CMD) || (state_r == ST_LEN) ||
            (state_r == ST_PAY) || (state_r == ST_CHK)) begin
            if (accept_s) begin
                tmo_cnt_s = TMO_ZERO;
            end else if (tmo_cnt_r == TMO_LAST) begin
                tmo_cnt_s     = TMO_ZERO;
                err_timeout_s = 1'b1;
                state_s       = ST_IDLE;
            end else begin
                tmo_cnt_s = tmo_cnt_r + TMO_ONE;
            end
        end else begin
            tmo_cnt_s = TMO_ZERO;
        end
`endif

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_r       <= 8'd0;
            len_r       <= 8'd0;
            chk_r       <= 8'd0;
            wr_r        <= PTR_ZERO;
            rd_r        <= PTR_ZERO;
            cmd_pulse_r <= {NUM_CMD{1'b0}};
            cmd_code_r  <= 8'd0;
            frame_ok_r  <= 1'b0;
            pld_data_r  <= 8'd0;
            pld_valid_r <= 1'b0;
            pld_last_r  <= 1'b0;
            err_chk_r   <= 1'b0;
            err_len_r   <= 1'b0;
            err_cmd_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_r       <= cmd_s;
            len_r       <= len_s;
            chk_r       <= chk_s;
            wr_r        <= wr_s;
            rd_r        <= rd_s;
            cmd_pulse_r <= cmd_pulse_s;
            cmd_code_r  <= cmd_code_s;
            frame_ok_r  <= frame_ok_s;
            pld_data_r  <= pld_data_s;
            pld_valid_r <= pld_valid_s;
            pld_last_r  <= pld_last_s;
            err_chk_r   <= err_chk_s;
            err_len_r   <= err_len_s;
            err_cmd_r   <= err_cmd_s;
            busy_r      <= busy_s;
        end
    end

    // Payload buffer write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            pay_mem[wr_r[ADDR_W-1:0]] <= rx_data;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    // Inter-byte timeout counter and its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r     <= TMO_ZERO;
            err_timeout_r <= 1'b0;
        end else begin
            tmo_cnt_r     <= tmo_cnt_s;
            err_timeout_r <= err_timeout_s;
        end
    end
    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

    assign rx_ready  = rx_ready_s;
    assign cmd_pulse = cmd_pulse_r;
    assign cmd_code  = cmd_code_r;
    assign frame_ok  = frame_ok_r;
    assign pld_data  = pld_data_r;
    assign pld_valid = pld_valid_r;
    assign pld_last  = pld_last_r;
    assign err_chk   = err_chk_r;
    assign err_len   = err_len_r;
    assign err_cmd   = err_cmd_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Self-checking bench for uart_cmd_parser (NUM_CMD=4, MAX_LEN=16,
// TIMEOUT_CYCLES=100). A monitor turns output strobes and payload handshakes
// into an event list; a frame-level reference parser computes the expected
// list from the byte stream that was sent.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int NUM_CMD = 4;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 100;

    logic               clk;
    logic               rst_n;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [NUM_CMD-1:0] cmd_pulse;
    logic [7:0]         cmd_code;
    logic               frame_ok;
    logic [7:0]         pld_data;
    logic               pld_valid;
    logic               pld_ready;
    logic               pld_last;
    logic               err_chk;
    logic               err_len;
    logic               err_cmd;
    logic               err_timeout;
    logic               busy;

    uart_cmd_parser #(
        .NUM_CMD(NUM_CMD), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .cmd_pulse(cmd_pulse), .cmd_code(cmd_code),
        .frame_ok(frame_ok), .pld_data(pld_data), .pld_valid(pld_valid),
        .pld_ready(pld_ready), .pld_last(pld_last), .err_chk(err_chk),
        .err_len(err_len), .err_cmd(err_cmd), .err_timeout(err_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event: {kind[2:0], value[7:0], last}; kinds 0=payload 1=frame 2=chk 3=len 4=cmd 5=timeout
    typedef logic [11:0] ev_t;
    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] stream_q[$];
    int         pld_mode = 0;   // 0: ready high, 1: random, 2: driven by the test

    function automatic ev_t mk_ev(input int kind, input logic [7:0] v, input logic last);
        logic [2:0] k;
        k = kind[2:0];
        return {k, v, last};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: record events and check payload hold under backpressure.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic       prev_last  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", pld_valid, 1);
                check("hold_data", pld_data, prev_data);
                check("hold_last", pld_last, prev_last);
            end
            if (frame_ok) begin
                got_q.push_back(mk_ev(1, cmd_code, 1'b0));
                check("pulse_onehot", cmd_pulse, 32'd1 << cmd_code);
            end
            if (err_chk)     got_q.push_back(mk_ev(2, 8'd0, 1'b0));
            if (err_len)     got_q.push_back(mk_ev(3, 8'd0, 1'b0));
            if (err_cmd)     got_q.push_back(mk_ev(4, 8'd0, 1'b0));
            if (err_timeout) got_q.push_back(mk_ev(5, 8'd0, 1'b0));
            if (pld_valid && pld_ready) got_q.push_back(mk_ev(0, pld_data, pld_last));
            prev_stall <= pld_valid && !pld_ready;
            prev_data  <= pld_data;
            prev_last  <= pld_last;
        end
    end

    // Payload ready driver.
    initial begin
        pld_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pld_mode == 0) pld_ready = 1'b1;
            else if (pld_mode == 1) pld_ready = 1'($urandom_range(0, 1));
        end
    end

    // Reference: parse the sent byte stream frame by frame.
    task automatic model_run();
        int i, n, cmd, len, x;
        i = 0;
        n = stream_q.size();
        while (i < n) begin
            if (stream_q[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 2 >= n) break;
            cmd = stream_q[i+1];
            len = stream_q[i+2];
            if (len > MAX_LEN) begin
                exp_q.push_back(mk_ev(3, 8'd0, 1'b0));
                i += 3;
                continue;
            end
            if (i + 3 + len >= n) break;
            x = cmd ^ len;
            for (int k = 0; k < len; k++) x = x ^ stream_q[i+3+k];
            if (stream_q[i+3+len] != 8'(x)) exp_q.push_back(mk_ev(2, 8'd0, 1'b0));
            else if (cmd >= NUM_CMD) exp_q.push_back(mk_ev(4, 8'd0, 1'b0));
            else begin
                exp_q.push_back(mk_ev(1, 8'(cmd), 1'b0));
                for (int k = 0; k < len; k++)
                    exp_q.push_back(mk_ev(0, stream_q[i+3+k], k == len - 1));
            end
            i += 4 + len;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!got && n < 1000) begin
            @(negedge clk);
            got = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!got) check("rx_accept", {31'd0, got}, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000 && (busy || pld_valid)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy || pld_valid) check("idle_wait", {31'd0, busy | pld_valid}, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  n;
        logic [2:0]  kind;
        logic [7:0]  code;
        logic [3:0]  npld;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] held;
    logic [7:0] b;
    int         np;
    logic [2:0] k0;

    initial begin
        vecs[0] = '{64'hA501021122300000, 4'd6, 3'd1, 8'h01, 4'd2};
        vecs[1] = '{64'hA501021122310000, 4'd6, 3'd2, 8'h00, 4'd0};
        vecs[2] = '{64'hA500200000000000, 4'd3, 3'd3, 8'h00, 4'd0};
        vecs[3] = '{64'hA503000300000000, 4'd4, 3'd1, 8'h03, 4'd0};
        vecs[4] = '{64'h00FF11A503000300, 4'd7, 3'd1, 8'h03, 4'd0};
        vecs[5] = '{64'hA507000700000000, 4'd4, 3'd4, 8'h00, 4'd0};
        vecs[6] = '{64'hA500110000000000, 4'd3, 3'd3, 8'h00, 4'd0};
        vecs[7] = '{64'hA50201A5A6000000, 4'd5, 3'd1, 8'h02, 4'd1};

        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_cmd_pulse", cmd_pulse, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_pld_valid", pld_valid, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_errs", {err_chk, err_len, err_cmd, err_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames
        held = 8'd0;
        for (int v = 0; v < 8; v++) begin
            got_q.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                b = vecs[v].bytes[63 - 8*i -: 8];
                send_byte(b);
            end
            wait_idle();
            k0 = (got_q.size() > 0) ? got_q[0][11:9] : 3'd7;
            check($sformatf("vec%0d_kind", v), k0, vecs[v].kind);
            if (vecs[v].kind == 3'd1) begin
                held = vecs[v].code;
                check($sformatf("vec%0d_code", v), (got_q.size() > 0) ? got_q[0][8:1] : 8'hXX, vecs[v].code);
            end
            np = 0;
            foreach (got_q[i]) if (got_q[i][11:9] == 3'd0) np++;
            check($sformatf("vec%0d_npld", v), np, vecs[v].npld);
            check($sformatf("vec%0d_cmd_code", v), cmd_code, held);
        end

        // Error timing: strobe for one cycle, nothing else, busy already low
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h31);
        check("t2_err_chk", err_chk, 1);
        check("t2_busy", busy, 0);
        check("t2_frame_ok", frame_ok, 0);
        check("t2_pld_valid", pld_valid, 0);
        @(posedge clk);
        #1;
        check("t2_err_chk_drop", err_chk, 0);

        // Good frame latency plus 5-cycle backpressure on the last payload byte
        pld_mode = 2;
        pld_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h30);
        check("t1_frame_ok", frame_ok, 1);
        check("t1_cmd_pulse", cmd_pulse, 4'b0010);
        check("t1_cmd_code", cmd_code, 8'h01);
        check("t1_pld_valid", pld_valid, 1);
        check("t1_pld_data0", pld_data, 8'h11);
        check("t1_pld_last0", pld_last, 0);
        check("t1_rx_ready", rx_ready, 0);
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t1_frame_ok_drop", frame_ok, 0);
        check("t1_pld_data1", pld_data, 8'h22);
        check("t1_pld_last1", pld_last, 1);
        pld_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("t5_data", pld_data, 8'h22);
            check("t5_last", pld_last, 1);
            check("t5_valid", pld_valid, 1);
            check("t5_rx_ready", rx_ready, 0);
        end
        pld_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5_drained", pld_valid, 0);
        check("t5_idle", busy, 0);
        check("t5_rx_ready_back", rx_ready, 1);
        @(posedge clk);
        #1;
        check("t5_sync_taken", busy, 1);
        rx_valid = 1'b0;
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
        check("t3_cmd_pulse", cmd_pulse, 4'b1000);
        check("t3_no_payload", pld_valid, 0);
        check("t3_idle", busy, 0);
        pld_mode = 0;
        wait_idle();

        // Reset in the middle of a payload
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_code", cmd_code, 0);
        check("rst_mid_pld_valid", pld_valid, 0);
        check("rst_mid_rx_ready", rx_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef UART_CMD_TIMEOUT_EN
        begin
            int n;
            send_byte(8'hA5);
            send_byte(8'h01);
            n = 0;
            while (!err_timeout && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("tmo_cycles", n, TMO);
            check("tmo_idle", busy, 0);
            wait_idle();
        end
`endif

        // Randomized frame stream against the reference parser
        got_q.delete();
        exp_q.delete();
        stream_q.delete();
        pld_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int r, len, cmd;
            logic [7:0] x;
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                stream_q.push_back(b);
            end
            cmd = $urandom_range(0, 5);
            r = $urandom_range(0, 9);
            len = (r == 0) ? 17 + $urandom_range(0, 1) : (r == 1) ? 16 : (r == 2) ? 0 : $urandom_range(1, 15);
            stream_q.push_back(8'hA5);
            stream_q.push_back(8'(cmd));
            stream_q.push_back(8'(len));
            if (len > MAX_LEN) continue;
            x = 8'(cmd ^ len);
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                stream_q.push_back(b);
            end
            if ($urandom_range(0, 4) == 0) x = x ^ 8'h5A;
            stream_q.push_back(x);
        end
        foreach (stream_q[i]) begin
            send_byte(stream_q[i]);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        model_run();
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_ev%0d", i), got_q[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
